// File: rtl/pe_seq_ctrl_if.sv
// Handshake bundle between pe_seq_ctrl and its surroundings: load stream, ALU result,
// forward-to-next-PE stream, alpha output stream and status.
interface pe_seq_ctrl_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ITER_NUM = 8
);
    localparam int unsigned ITER_W = $clog2(ITER_NUM + 1);

    logic              din_pe_v;
    logic              alu_v;
    logic [DATA_W-1:0] alu_data;
    logic              dout_pe_rdy;
    logic              load_v;
    logic              cmpt_v;
    logic              shift_v;
    logic              dout_tx_v;
    logic [DATA_W-1:0] dout_tx;
    logic              dout_pe_v;
    logic [DATA_W-1:0] dout_pe;
    logic [ITER_W-1:0] iter;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output din_pe_v, alu_v, alu_data, dout_pe_rdy,
        input  load_v, cmpt_v, shift_v, dout_tx_v, dout_tx, dout_pe_v, dout_pe,
        input  iter, busy, done, err
    );

    modport slave (
        input  din_pe_v, alu_v, alu_data, dout_pe_rdy,
        output load_v, cmpt_v, shift_v, dout_tx_v, dout_tx, dout_pe_v, dout_pe,
        output iter, busy, done, err
    );
endinterface

// File: rtl/pe_seq_ctrl.sv
// PE sequencer: load -> compute -> transmit (-> shift) per iteration, then alpha output.
// Define PE_SEQ_SHIFT_EN to insert the SHIFT phase between TRANSMIT and LOAD.
module pe_seq_ctrl #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LOAD_NUM  = 16,
    parameter int unsigned INST_NUM  = 64,
    parameter int unsigned TX_NUM    = 4,
    parameter int unsigned ITER_NUM  = 8,
    parameter int unsigned ALPHA_NUM = 4,
    parameter int unsigned SHIFT_NUM = 4
) (
    input logic            clk,
    input logic            rst,
    pe_seq_ctrl_if.slave   pe_bus
);
    localparam int unsigned ITER_W  = $clog2(ITER_NUM + 1);
    localparam int unsigned MAX_A   = (LOAD_NUM > INST_NUM) ? LOAD_NUM : INST_NUM;
    localparam int unsigned MAX_B   = (TX_NUM > SHIFT_NUM) ? TX_NUM : SHIFT_NUM;
    localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_MAX = (MAX_C > ALPHA_NUM) ? MAX_C : ALPHA_NUM;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StCompute, StTransmit, StShift, StOutput
    } state_e;

    state_e              r_state, w_state_d;
    logic [CNT_W-1:0]    r_cnt, w_cnt_d;
    logic [ITER_W-1:0]   r_iter, w_iter_d;
    logic                r_tx_v, w_tx_v_d;
    logic [DATA_W-1:0]   r_tx, w_tx_d;
    logic                r_pe_v, w_pe_v_d;
    logic [DATA_W-1:0]   r_pe, w_pe_d;
    logic                r_done, w_done_d;
    logic                r_err, w_err_d;
    logic                w_hs;
    logic                w_cap;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_iter  <= '0;
            r_tx_v  <= 1'b0;
            r_tx    <= '0;
            r_pe_v  <= 1'b0;
            r_pe    <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_iter  <= w_iter_d;
            r_tx_v  <= w_tx_v_d;
            r_tx    <= w_tx_d;
            r_pe_v  <= w_pe_v_d;
            r_pe    <= w_pe_d;
            r_done  <= w_done_d;
            r_err   <= w_err_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_iter_d  = r_iter;
        w_tx_v_d  = 1'b0;
        w_tx_d    = r_tx;
        w_pe_v_d  = r_pe_v;
        w_pe_d    = r_pe;
        w_done_d  = 1'b0;
        w_err_d   = r_err;
        w_hs      = 1'b0;
        w_cap     = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (pe_bus.din_pe_v) begin
                    w_state_d = StLoad;
                    w_cnt_d   = CNT_W'(1);
                    w_iter_d  = '0;
                end
            end
            StLoad: begin
                if (pe_bus.din_pe_v) begin
                    if (r_cnt == CNT_W'(LOAD_NUM - 1)) begin
                        w_state_d = StCompute;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
            end
            StCompute: begin
                if (pe_bus.din_pe_v) w_err_d = 1'b1;
                if (r_cnt == CNT_W'(INST_NUM - 1)) begin
                    w_cnt_d = '0;
                    if (r_iter == ITER_W'(ITER_NUM - 1)) begin
                        w_state_d = StOutput;
                    end else begin
                        w_state_d = StTransmit;
                        w_iter_d  = r_iter + ITER_W'(1);
                    end
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            StTransmit: begin
                if (pe_bus.din_pe_v) w_err_d = 1'b1;
                w_tx_v_d = 1'b1;
                w_tx_d   = pe_bus.alu_data;
                if (r_cnt == CNT_W'(TX_NUM - 1)) begin
                    w_cnt_d = '0;
`ifdef PE_SEQ_SHIFT_EN
                    w_state_d = StShift;
`else
                    w_state_d = StLoad;
`endif
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
`ifdef PE_SEQ_SHIFT_EN
            StShift: begin
                if (pe_bus.din_pe_v) w_err_d = 1'b1;
                if (r_cnt == CNT_W'(SHIFT_NUM - 1)) begin
                    w_state_d = StLoad;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
`endif
            StOutput: begin
                if (pe_bus.din_pe_v) w_err_d = 1'b1;
                w_hs  = r_pe_v & pe_bus.dout_pe_rdy;
                w_cap = pe_bus.alu_v & (~r_pe_v | pe_bus.dout_pe_rdy);
                // A beat arriving while the held word is stalled is dropped.
                if (pe_bus.alu_v && r_pe_v && !pe_bus.dout_pe_rdy) w_err_d = 1'b1;
                if (w_hs && (r_cnt == CNT_W'(ALPHA_NUM - 1))) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                    w_pe_v_d  = 1'b0;
                    w_done_d  = 1'b1;
                end else begin
                    if (w_hs) w_cnt_d = r_cnt + CNT_W'(1);
                    if (w_cap) begin
                        w_pe_v_d = 1'b1;
                        w_pe_d   = pe_bus.alu_data;
                    end else if (w_hs) begin
                        w_pe_v_d = 1'b0;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    assign pe_bus.load_v    = pe_bus.din_pe_v & ((r_state == StIdle) | (r_state == StLoad));
    assign pe_bus.cmpt_v    = (r_state == StCompute);
`ifdef PE_SEQ_SHIFT_EN
    assign pe_bus.shift_v   = (r_state == StShift);
`else
    assign pe_bus.shift_v   = 1'b0;
`endif
    assign pe_bus.dout_tx_v = r_tx_v;
    assign pe_bus.dout_tx   = r_tx;
    assign pe_bus.dout_pe_v = r_pe_v;
    assign pe_bus.dout_pe   = r_pe;
    assign pe_bus.iter      = r_iter;
    assign pe_bus.busy      = (r_state != StIdle);
    assign pe_bus.done      = r_done;
    assign pe_bus.err       = r_err;
endmodule
